// File: rtl/bnn_pkg.sv
// Shared constants for the 8-8-4 BNN layer sequencer: topology, FSM encoding, weight map.
// BNN_PER_NEURON_THRESH_EN adds the per-neuron threshold address window.
package bnn_pkg;

  localparam int unsigned NUM_L1      = 8;
  localparam int unsigned NUM_L2      = 8;
  localparam int unsigned NUM_L3      = 4;
  localparam int unsigned NUM_NEURONS = NUM_L1 + NUM_L2 + NUM_L3;
  localparam int unsigned THRESHOLD   = 4;

  typedef logic [2:0] state_t;
  localparam state_t StIdle = 3'd0;
  localparam state_t StL1   = 3'd1;
  localparam state_t StL2   = 3'd2;
  localparam state_t StL3   = 3'd3;
  localparam state_t StDone = 3'd4;

  // Neuron index at which each layer hands over to the next.
  localparam logic [4:0] LastL1 = 5'(NUM_L1 - 1);
  localparam logic [4:0] LastL2 = 5'(NUM_L1 + NUM_L2 - 1);
  localparam logic [4:0] LastL3 = 5'(NUM_NEURONS - 1);

  localparam logic [5:0] WeightBase = 6'd0;
`ifdef BNN_PER_NEURON_THRESH_EN
  localparam logic [5:0] ThreshBase = 6'd32;
`endif

  localparam logic [7:0] DEFAULT_WEIGHTS [NUM_NEURONS] = '{
    8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h55, 8'hAA, 8'hC3, 8'h96,
    8'h69, 8'h1E, 8'hE1, 8'h78, 8'h87, 8'h5A, 8'hB4, 8'h2D,
    8'hCC, 8'h33, 8'h99, 8'h66
  };

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational XNOR-popcount: counts positions where activation and weight agree (0..8).
module bnn_xnor_popcount (
  input  logic [7:0] act_i,
  input  logic [7:0] weight_i,
  output logic [3:0] sum_o
);

  logic [7:0] match;

  always_comb begin
    match = ~(act_i ^ weight_i);
    sum_o = '0;
    for (int i = 0; i < 8; i++) begin
      sum_o = sum_o + {3'b000, match[i]};
    end
  end

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Time-multiplexed 8-8-4 BNN: one shared XNOR-popcount engine evaluates one neuron per cycle.
// Define BNN_PER_NEURON_THRESH_EN for writable per-neuron thresholds (addresses 32-51).
module bnn_layer_sequencer
  import bnn_pkg::*;
#(
  parameter int unsigned Threshold = THRESHOLD
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_data_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [3:0] out_data_o,
  output logic [3:0] out_hidden_o,
  output logic       busy_o,
  input  logic       wld_en_i,
  input  logic [5:0] wld_addr_i,
  input  logic [7:0] wld_data_i
);

  state_t     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [7:0] act_a_q, act_a_d;
  logic [7:0] act_b_q, act_b_d;
  logic [3:0] res_q, res_d;
  logic [7:0] weights_q [NUM_NEURONS];

  logic [7:0] src;
  logic [3:0] sum;
  logic [3:0] thr_cur;
  logic       fire;
  logic       wr_ok;
  logic       w_we;

  assign wr_ok = (state_q == StIdle) || (state_q == StDone);
  assign w_we  = wld_en_i && wr_ok && (wld_addr_i >= WeightBase) &&
                 (wld_addr_i < WeightBase + 6'(NUM_NEURONS));

  assign src = (state_q == StL2) ? act_b_q : act_a_q;

  bnn_xnor_popcount u_popcount (
    .act_i    (src),
    .weight_i (weights_q[idx_q]),
    .sum_o    (sum)
  );

`ifdef BNN_PER_NEURON_THRESH_EN
  logic [3:0] thr_q [NUM_NEURONS];
  logic       t_we;

  assign t_we    = wld_en_i && wr_ok && (wld_addr_i >= ThreshBase) &&
                   (wld_addr_i < ThreshBase + 6'(NUM_NEURONS));
  assign thr_cur = thr_q[idx_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_NEURONS; i++) thr_q[i] <= 4'(Threshold);
    end else if (t_we) begin
      thr_q[5'(wld_addr_i - ThreshBase)] <= wld_data_i[3:0];
    end
  end
`else
  assign thr_cur = 4'(Threshold);
`endif

  assign fire = (sum >= thr_cur);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    act_a_d = act_a_q;
    act_b_d = act_b_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          act_a_d = in_data_i;
          idx_d   = '0;
          state_d = StL1;
        end
      end
      StL1: begin
        act_b_d[idx_q[2:0]] = fire;
        idx_d = idx_q + 5'd1;
        if (idx_q == LastL1) state_d = StL2;
      end
      StL2: begin
        act_a_d[idx_q[2:0]] = fire;
        idx_d = idx_q + 5'd1;
        if (idx_q == LastL2) state_d = StL3;
      end
      StL3: begin
        res_d[idx_q[1:0]] = fire;
        idx_d = idx_q + 5'd1;
        if (idx_q == LastL3) state_d = StDone;
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      act_a_q <= '0;
      act_b_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      act_a_q <= act_a_d;
      act_b_q <= act_b_d;
      res_q   <= res_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_NEURONS; i++) weights_q[i] <= DEFAULT_WEIGHTS[i];
    end else if (w_we) begin
      weights_q[5'(wld_addr_i - WeightBase)] <= wld_data_i;
    end
  end

  assign in_ready_o   = (state_q == StIdle);
  assign out_valid_o  = (state_q == StDone);
  assign busy_o       = (state_q == StL1) || (state_q == StL2) || (state_q == StL3);
  assign out_data_o   = res_q;
  // Layer-2 results land in act_a; neurons 12-15 occupy its upper nibble.
  assign out_hidden_o = act_a_q[7:4];

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Self-checking bench for bnn_layer_sequencer: table-driven uniform-weight vectors plus
// directed handshake, write-drop, threshold-window and mid-compute reset sequences.
module tb_bnn_layer_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic [7:0] in_data_i = '0;
  logic       out_valid_o;
  logic       out_ready_i = 1'b0;
  logic [3:0] out_data_o;
  logic [3:0] out_hidden_o;
  logic       busy_o;
  logic       wld_en_i = 1'b0;
  logic [5:0] wld_addr_i = '0;
  logic [7:0] wld_data_i = '0;

  int checks = 0;
  int failures = 0;

  bnn_layer_sequencer u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_hidden_o (out_hidden_o),
    .busy_o       (busy_o),
    .wld_en_i     (wld_en_i),
    .wld_addr_i   (wld_addr_i),
    .wld_data_i   (wld_data_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] w;
    logic [7:0] x;
    logic [3:0] exp_out;
    logic [3:0] exp_hid;
  } vec_t;

  vec_t vecs [7];

  // Independent copy of the reset weight table for the reference model.
  logic [7:0] ref_w [20] = '{
    8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h55, 8'hAA, 8'hC3, 8'h96,
    8'h69, 8'h1E, 8'hE1, 8'h78, 8'h87, 8'h5A, 8'hB4, 8'h2D,
    8'hCC, 8'h33, 8'h99, 8'h66
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_all(input logic [7:0] w);
    for (int i = 0; i < 20; i++) begin
      wld_en_i = 1'b1;
      wld_addr_i = 6'(i);
      wld_data_i = w;
      step();
    end
    wld_en_i = 1'b0;
  endtask

  task automatic write1(input logic [5:0] addr, input logic [7:0] data);
    wld_en_i = 1'b1;
    wld_addr_i = addr;
    wld_data_i = data;
    step();
    wld_en_i = 1'b0;
  endtask

  task automatic wait_done(inout int lat);
    while (!out_valid_o && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic start(input logic [7:0] x);
    in_valid_i = 1'b1;
    in_data_i = x;
    step();
    in_valid_i = 1'b0;
  endtask

  task automatic run(input logic [7:0] x, output int lat);
    start(x);
    lat = 0;
    wait_done(lat);
  endtask

  task automatic handshake(input string name);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    check({name, "_in_ready_after"}, 32'(in_ready_o), 32'd1);
    check({name, "_out_valid_after"}, 32'(out_valid_o), 32'd0);
  endtask

  function automatic int pc(input logic [7:0] v);
    int s = 0;
    for (int i = 0; i < 8; i++) s += int'(v[i]);
    return s;
  endfunction

  function automatic logic [7:0] model(input logic [7:0] x);
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] r;
    a = x;
    b = '0;
    r = '0;
    for (int n = 0; n < 8; n++) b[n] = (pc(~(a ^ ref_w[n])) >= 4);
    for (int n = 0; n < 8; n++) a[n] = (pc(~(b ^ ref_w[8 + n])) >= 4);
    for (int n = 0; n < 4; n++) r[n] = (pc(~(a ^ ref_w[16 + n])) >= 4);
    return {a[7:4], r};
  endfunction

  initial begin
    int lat;
    logic [7:0] exp_m;
    logic [7:0] xs [2];

    vecs[0] = '{w: 8'hFF, x: 8'hFF, exp_out: 4'hF, exp_hid: 4'hF};
    vecs[1] = '{w: 8'h00, x: 8'hFF, exp_out: 4'h0, exp_hid: 4'hF};
    vecs[2] = '{w: 8'h00, x: 8'h00, exp_out: 4'hF, exp_hid: 4'h0};
    vecs[3] = '{w: 8'hFF, x: 8'h00, exp_out: 4'h0, exp_hid: 4'h0};
    vecs[4] = '{w: 8'h0F, x: 8'h0F, exp_out: 4'hF, exp_hid: 4'hF};
    vecs[5] = '{w: 8'h0F, x: 8'h07, exp_out: 4'hF, exp_hid: 4'hF};
    vecs[6] = '{w: 8'h07, x: 8'hFF, exp_out: 4'h0, exp_hid: 4'hF};

    #12;
    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_out_data", 32'(out_data_o), 32'd0);
    check("rst_out_hidden", 32'(out_hidden_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    for (int v = 0; v < 7; v++) begin
      load_all(vecs[v].w);
      start(vecs[v].x);
      check($sformatf("vec%0d_busy", v), 32'(busy_o), 32'd1);
      lat = 0;
      wait_done(lat);
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'd20);
      check($sformatf("vec%0d_out_data", v), 32'(out_data_o), 32'(vecs[v].exp_out));
      check($sformatf("vec%0d_out_hidden", v), 32'(out_hidden_o), 32'(vecs[v].exp_hid));
      handshake($sformatf("vec%0d", v));
    end

    // Back-pressure in DONE with a competing in_valid that must be ignored.
    load_all(8'hFF);
    run(8'hFF, lat);
    in_valid_i = 1'b1;
    in_data_i = 8'h00;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("hold%0d_out_valid", c), 32'(out_valid_o), 32'd1);
      check($sformatf("hold%0d_out_data", c), 32'(out_data_o), 32'hF);
      check($sformatf("hold%0d_in_ready", c), 32'(in_ready_o), 32'd0);
    end
    in_valid_i = 1'b0;
    handshake("hold");
    check("hold_busy_idle", 32'(busy_o), 32'd0);

    // Write during compute is dropped.
    start(8'hFF);
    for (int c = 0; c < 4; c++) step();
    write1(6'd16, 8'h00);
    lat = 5;
    wait_done(lat);
    check("wdrop_latency", 32'(lat), 32'd20);
    check("wdrop_out_data", 32'(out_data_o), 32'hF);
    handshake("wdrop");
    run(8'hFF, lat);
    check("wdrop_rerun_out_data", 32'(out_data_o), 32'hF);

    // Write in DONE takes effect on the next run.
    write1(6'd16, 8'h00);
    handshake("wdone");
    run(8'hFF, lat);
    check("wdone_rerun_out_data", 32'(out_data_o), 32'hE);
    handshake("wdone2");

    // Threshold window at address 48 (neuron 16).
    load_all(8'hFF);
    write1(6'd48, 8'h09);
    run(8'hFF, lat);
`ifdef BNN_PER_NEURON_THRESH_EN
    check("thr16_out_data", 32'(out_data_o), 32'hE);
`else
    check("thr16_ignored_out_data", 32'(out_data_o), 32'hF);
`endif
    handshake("thr");

    // Reset 10 cycles into compute.
    start(8'hFF);
    for (int c = 0; c < 9; c++) step();
    check("mid_busy_before_rst", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    #2;
    check("mid_rst_out_valid", 32'(out_valid_o), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready_o), 32'd1);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_out_data", 32'(out_data_o), 32'd0);
    check("mid_rst_out_hidden", 32'(out_hidden_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    // Default weights (and thresholds) restored by reset.
    xs[0] = 8'hFF;
    xs[1] = 8'h5A;
    for (int k = 0; k < 2; k++) begin
      exp_m = model(xs[k]);
      run(xs[k], lat);
      check($sformatf("dflt%0d_latency", k), 32'(lat), 32'd20);
      check($sformatf("dflt%0d_out_data", k), 32'(out_data_o), 32'(exp_m[3:0]));
      check($sformatf("dflt%0d_out_hidden", k), 32'(out_hidden_o), 32'(exp_m[7:4]));
      handshake($sformatf("dflt%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
